// File: rtl/pmp_dmp_csr_regs_pkg.sv
// Shared types for the PMP / JITDomain DMP CSR register slice.
// Config byte layouts, address modes and the CSR kind encoding.
package pmp_dmp_csr_regs_pkg;

  typedef enum logic [1:0] {
    ADDR_OFF   = 2'b00,
    ADDR_TOR   = 2'b01,
    ADDR_NA4   = 2'b10,
    ADDR_NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;

  typedef logic [3:0] dmp_domain_t;

  localparam dmp_domain_t DOMI = 4'hF;

  typedef struct packed {
    logic        locked;
    logic [2:0]  reserved;
    dmp_domain_t domain;
  } dmpcfg_t;

  typedef enum logic [1:0] {
    KIND_PMPCFG  = 2'd0,
    KIND_PMPADDR = 2'd1,
    KIND_DMPCFG  = 2'd2,
    KIND_RSVD    = 2'd3
  } csr_pmp_kind_t;

endpackage

// File: rtl/pmp_dmp_csr_regs_if.sv
// CSR-unit side bus of the PMP/DMP register file.
// master = CSR unit, slave = register file.
interface pmp_dmp_csr_regs_if
  import pmp_dmp_csr_regs_pkg::*;
#(
  parameter int XLEN = 64
);
  logic            wr_valid_i;
  csr_pmp_kind_t   wr_kind_i;
  logic [3:0]      wr_idx_i;
  logic [XLEN-1:0] wr_data_i;
  csr_pmp_kind_t   rd_kind_i;
  logic [3:0]      rd_idx_i;
  logic [XLEN-1:0] rd_data_o;
  logic            flush_o;
  logic            wr_ignored_o;

  modport master (
    output wr_valid_i, wr_kind_i, wr_idx_i, wr_data_i,
    output rd_kind_i, rd_idx_i,
    input  rd_data_o, flush_o, wr_ignored_o
  );

  modport slave (
    input  wr_valid_i, wr_kind_i, wr_idx_i, wr_data_i,
    input  rd_kind_i, rd_idx_i,
    output rd_data_o, flush_o, wr_ignored_o
  );
endinterface

// File: rtl/pmp_cfg_legalize.sv
// One config byte lane: WARL legalisation plus lock/implemented filter.
// Handles both pmpcfg and dmpcfg byte layouts.
module pmp_cfg_legalize
  import pmp_dmp_csr_regs_pkg::*;
(
  input  logic       is_dmp_i,
  input  logic       impl_i,
  input  logic       old_locked_i,
  input  logic [7:0] wr_byte_i,
  output logic [7:0] new_byte_o,
  output logic       eligible_o
);

  pmpcfg_t pc;
  dmpcfg_t dc;

  always_comb begin
    pc = pmpcfg_t'(wr_byte_i);
    pc.reserved = '0;
    // W without R is a reserved combination
    if (pc.access_type.w && !pc.access_type.r)
      pc.access_type.w = 1'b0;
    dc = dmpcfg_t'(wr_byte_i);
    dc.reserved = '0;
    new_byte_o = is_dmp_i ? 8'(dc) : 8'(pc);
    eligible_o = impl_i && !old_locked_i;
  end

endmodule

// File: rtl/pmp_dmp_csr_regs.sv
// PMP pmpcfg/pmpaddr and DMP dmpcfg register file feeding the checker.
// Applies WARL and lock rules, reports flush and ignored-write events.
module pmp_dmp_csr_regs
  import pmp_dmp_csr_regs_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int PMP_LEN    = 54,
  parameter int NR_ENTRIES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  pmp_dmp_csr_regs_if.slave         bus,
  output logic [15:0][PMP_LEN-1:0]  conf_addr_o,
  output pmpcfg_t [15:0]            pmpconf_o,
  output dmpcfg_t [15:0]            dmpconf_o
);

  localparam logic [4:0] NR = 5'(NR_ENTRIES);

  logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
  pmpcfg_t [15:0]           pcfg_q, pcfg_d;
  dmpcfg_t [15:0]           dcfg_q, dcfg_d;
  logic                     flush_q, flush_d;
  logic                     ign_q, ign_d;

  logic            is_dmp;
  logic [7:0][7:0] lane_new;
  logic [7:0]      lane_ok;
  logic            grp;

  assign is_dmp = bus.wr_kind_i == KIND_DMPCFG;
  assign grp    = bus.wr_idx_i[0];

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [3:0] e;
    logic       lk;
    assign e  = {grp, 3'(k)};
    assign lk = is_dmp ? dcfg_q[e].locked : pcfg_q[e].locked;

    pmp_cfg_legalize u_leg (
      .is_dmp_i     (is_dmp),
      .impl_i       ({1'b0, e} < NR),
      .old_locked_i (lk),
      .wr_byte_i    (bus.wr_data_i[8*k +: 8]),
      .new_byte_o   (lane_new[k]),
      .eligible_o   (lane_ok[k])
    );
  end

  logic [3:0] ai, an;
  logic       addr_ok;

  assign ai = bus.wr_idx_i;
  assign an = ai + 4'd1;

  // A locked TOR entry above also freezes this entry's address
  always_comb begin
    addr_ok = ({1'b0, ai} < NR) && !pcfg_q[ai].locked;
    if (ai != 4'd15 && ({1'b0, an} < NR) &&
        pcfg_q[an].locked &&
        pcfg_q[an].addr_mode == ADDR_TOR)
      addr_ok = 1'b0;
  end

  logic any_ok;

  always_comb begin
    addr_d = addr_q;
    pcfg_d = pcfg_q;
    dcfg_d = dcfg_q;
    any_ok = 1'b0;
    if (bus.wr_valid_i) begin
      unique case (1'b1)
        bus.wr_kind_i == KIND_PMPCFG: begin
          for (int k = 0; k < 8; k++)
            if (lane_ok[k])
              pcfg_d[{grp, 3'(k)}] = pmpcfg_t'(lane_new[k]);
          any_ok = |lane_ok;
        end
        bus.wr_kind_i == KIND_DMPCFG: begin
          for (int k = 0; k < 8; k++)
            if (lane_ok[k])
              dcfg_d[{grp, 3'(k)}] = dmpcfg_t'(lane_new[k]);
          any_ok = |lane_ok;
        end
        bus.wr_kind_i == KIND_PMPADDR: begin
          if (addr_ok)
            addr_d[ai] = bus.wr_data_i[PMP_LEN-1:0];
          any_ok = addr_ok;
        end
        default: any_ok = 1'b0;
      endcase
    end
    flush_d = (addr_d != addr_q) ||
              (pcfg_d != pcfg_q) ||
              (dcfg_d != dcfg_q);
    ign_d   = bus.wr_valid_i && !any_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      pcfg_q  <= '0;
      dcfg_q  <= '0;
      flush_q <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      pcfg_q  <= pcfg_d;
      dcfg_q  <= dcfg_d;
      flush_q <= flush_d;
      ign_q   <= ign_d;
    end
  end

  logic [XLEN-1:0] rd;

  always_comb begin
    rd = '0;
    unique case (1'b1)
      bus.rd_kind_i == KIND_PMPCFG:
        for (int k = 0; k < 8; k++)
          rd[8*k +: 8] = pcfg_q[{bus.rd_idx_i[0], 3'(k)}];
      bus.rd_kind_i == KIND_DMPCFG:
        for (int k = 0; k < 8; k++)
          rd[8*k +: 8] = dcfg_q[{bus.rd_idx_i[0], 3'(k)}];
      bus.rd_kind_i == KIND_PMPADDR:
        rd[PMP_LEN-1:0] = addr_q[bus.rd_idx_i];
      default: rd = '0;
    endcase
  end

  assign bus.rd_data_o    = rd;
  assign bus.flush_o      = flush_q;
  assign bus.wr_ignored_o = ign_q;
  assign conf_addr_o      = addr_q;
  assign pmpconf_o        = pcfg_q;
  assign dmpconf_o        = dcfg_q;

endmodule
